alu_mc: RTL
===========

# alu_mc

Parametrised multi-cycle ALU for the MIPS datapath; successor to the single-cycle combinational ALU. Keeps the existing AND/OR/ADD/SUB/SLT control encodings and adds NOR, unsigned SLT, an iterative unsigned multiplier and an optional iterative unsigned divider. Operands enter and results leave through valid/ready handshakes, so the control unit can stall on long operations. All outputs are registered, and undefined opcodes are flagged.

## Interface
- WIDTH, 32, operand/result width; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- control  in  4  operation select.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  main result: low product word or quotient for MULTU/DIVU.
- hi  out  WIDTH  high product word or remainder; 0 for single-cycle ops.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow for ADD/SUB; 0 otherwise.
- err  out  1  illegal opcode or divide-by-zero.

## Operation
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed)
  - 0011 SLTU
  - 1100 NOR
  - 1000 MULTU
  - 1001 DIVU
- Every other opcode is illegal: result=0, hi=0, zero=1, err=1. No latching of stale results.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → DONE on accept of a single-cycle op.
  - IDLE → BUSY on accept of MULTU/DIVU.
  - BUSY → DONE when the iteration counter expires.
  - DONE → IDLE when out_ready is high.
- Accept occurs when in_valid && in_ready. a, b and control are captured on the accept edge; later changes are ignored.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf = operand signs agree (ADD) or differ (SUB) and the result sign differs from a.
- MULTU: shift-add, one bit per cycle, WIDTH iterations; {hi,result} = a*b, full 2*WIDTH-bit product.
- DIVU: restoring division, one bit per cycle, WIDTH iterations; result = a/b, hi = a%b.
- Divide by zero: result = all-ones, hi = a, err = 1. Still takes WIDTH cycles.
- Reset values: in_ready=0 during reset, then 1 (IDLE). out_valid=0, result=0, hi=0, zero=0, ovf=0, err=0.
- Reset mid-operation: the in-flight op is dropped, FSM goes to IDLE, and no out_valid is produced.
- Output backpressure: in DONE with out_ready=0, all outputs hold stable and in_ready stays 0.

## Timing
- Single-cycle ops: out_valid is high the cycle after the accept edge (latency 1).
- MULTU/DIVU: out_valid is high WIDTH cycles after the accept edge; busy for WIDTH-1 cycles in between.
- Throughput: one op per 2 cycles for single-cycle ops. The DONE→IDLE edge and the next accept cannot coincide; in_ready rises the cycle after the out_ready handshake.
- in_valid asserted with in_ready=0 is not accepted; the source must hold its values.

## Configuration
- ALU_DIV_EN defined: the DIVU datapath is compiled in, as described above.
- ALU_DIV_EN undefined: 1001 is treated as an illegal opcode (result=0, hi=0, err=1, latency 1). No divider logic is synthesised.

## Structure
- Package alu_pkg holds:
  - localparams for every opcode encoding;
  - the FSM state enum (IDLE/BUSY/DONE);
  - a function is_multicycle(control).
- Sub-module alu_mc_iter holds the shared shift register and iteration counter for MULTU/DIVU, with start/done ports. The divider portion is guarded by ALU_DIV_EN.
- The top module holds the FSM, handshake, single-cycle logic and output registers.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF+1 → result 0x80000000, ovf=1, zero=0, out_valid 1 cycle after accept; SUB 5-5 → result 0, zero=1, ovf=0.
- SLT a=0xFFFFFFFF, b=1 → result 1; SLTU with the same operands → result 0; NOR 0,0 → 0xFFFFFFFF.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, result=0x00000001; out_valid exactly 32 cycles after accept; in_ready low throughout.
- DIVU 100/7 → result 14, hi 2; DIVU 9/0 → result 0xFFFFFFFF, hi 9, err=1. Without ALU_DIV_EN: DIVU → err=1, latency 1.
- Hold out_ready=0 for 5 cycles after completion → outputs stable and in_ready=0; new in_valid is not accepted until the handshake completes.
- Assert rst at cycle 10 of a MULTU → next cycle: IDLE, out_valid=0, all outputs 0; a subsequent ADD 2+3 → result 5.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle MIPS ALU.
//   - opcode encodings carried on the 4-bit 'control' bus
//   - FSM state encoding for the top-level handshake controller
//   - is_multicycle(): selects ops that run through the iterative unit
// Build option: ALU_DIV_EN compiles in DIVU; without it 1001 is illegal.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // True for opcodes that go through the iterative multiply/divide unit.
  function automatic logic is_multicycle(input logic [3:0] control);
    logic mc;
    mc = (control == OP_MULTU);
`ifdef ALU_DIV_EN
    mc = mc || (control == OP_DIVU);
`endif
    return mc;
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shared iterative engine for MULTU (shift-add) and, when
// ALU_DIV_EN is defined, DIVU (restoring division). One bit per cycle,
// WIDTH iterations. The first iteration is performed on the start edge
// directly from the input operands, so 'done' is high during the cycle
// whose edge performs the final iteration; lo_next/hi_next then carry the
// finished result and the caller registers them on that same edge.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load operands and run iteration 1 on this edge
//   div_op          (ALU_DIV_EN only) 1 = divide, 0 = multiply
//   a, b            operands (a*b, or a/b)
//   done            this edge performs the last iteration
//   lo_next         low product word / quotient after this edge
//   hi_next         high product word / remainder after this edge
module alu_mc_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic             div_op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // hi_r/lo_r form the shared double-width shift register:
  //   multiply: {partial product, remaining multiplier bits}
  //   divide:   {partial remainder, dividend bits / quotient bits}
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] opnd_r;   // multiplicand or divisor
  logic [CW-1:0]    cnt_r;    // iterations already completed
  logic             busy_r;

  logic [WIDTH-1:0] cur_hi_s;
  logic [WIDTH-1:0] cur_lo_s;
  logic [WIDTH-1:0] cur_opnd_s;

  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [WIDTH-1:0] mul_lo_s;

`ifdef ALU_DIV_EN
  logic             div_r;
  logic             cur_div_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] div_hi_s;
  logic [WIDTH-1:0] div_lo_s;
`endif

  assign done = busy_r && (cnt_r == LAST_CNT);

  // Iteration source: fresh operands on start, shift register otherwise.
  always_comb begin
    cur_hi_s   = hi_r;
    cur_lo_s   = lo_r;
    cur_opnd_s = opnd_r;
    if (start) begin
      cur_hi_s = {WIDTH{1'b0}};
`ifdef ALU_DIV_EN
      cur_lo_s   = div_op ? a : b;
      cur_opnd_s = div_op ? b : a;
`else
      cur_lo_s   = b;
      cur_opnd_s = a;
`endif
    end else begin
      cur_hi_s   = hi_r;
      cur_lo_s   = lo_r;
      cur_opnd_s = opnd_r;
    end
  end

  // Shift-add step: add multiplicand when the multiplier LSB is set,
  // then shift the whole {carry,hi,lo} right by one.
  always_comb begin
    add_s    = {1'b0, cur_hi_s} + (cur_lo_s[0] ? {1'b0, cur_opnd_s} : {(WIDTH+1){1'b0}});
    mul_hi_s = add_s[WIDTH:1];
    mul_lo_s = {add_s[0], cur_lo_s[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  // Restoring step: shift next dividend bit into the remainder, subtract
  // the divisor and keep the difference only if it did not go negative.
  // With a zero divisor every trial succeeds, which naturally yields an
  // all-ones quotient and the dividend as remainder.
  always_comb begin
    cur_div_s = start ? div_op : div_r;
    rem_sh_s  = {cur_hi_s, cur_lo_s[WIDTH-1]};
    trial_s   = rem_sh_s - {1'b0, cur_opnd_s};
    if (trial_s[WIDTH]) begin
      div_hi_s = rem_sh_s[WIDTH-1:0];
      div_lo_s = {cur_lo_s[WIDTH-2:0], 1'b0};
    end else begin
      div_hi_s = trial_s[WIDTH-1:0];
      div_lo_s = {cur_lo_s[WIDTH-2:0], 1'b1};
    end
  end

  // Select the step result for the operation in flight.
  always_comb begin
    if (cur_div_s) begin
      hi_next = div_hi_s;
      lo_next = div_lo_s;
    end else begin
      hi_next = mul_hi_s;
      lo_next = mul_lo_s;
    end
  end
`else
  // Only the multiplier exists in this build.
  always_comb begin
    hi_next = mul_hi_s;
    lo_next = mul_lo_s;
  end
`endif

  // Shift register, operand hold and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      opnd_r <= {WIDTH{1'b0}};
`ifdef ALU_DIV_EN
      div_r  <= 1'b0;
`endif
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= CW'(1);
      hi_r   <= hi_next;
      lo_r   <= lo_next;
      opnd_r <= cur_opnd_s;
`ifdef ALU_DIV_EN
      div_r  <= div_op;
`endif
    end else if (busy_r) begin
      hi_r   <= hi_next;
      lo_r   <= lo_next;
      cnt_r  <= cnt_r + CW'(1);
      busy_r <= !done;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS ALU with valid/ready handshakes.
// Single-cycle ops (AND/OR/ADD/SUB/SLT/SLTU/NOR) complete one cycle after
// accept; MULTU (and DIVU when ALU_DIV_EN is defined) run WIDTH cycles in
// alu_mc_iter. Undefined opcodes complete in one cycle with err=1.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   a, b, control        operands and opcode, captured on accept
//   out_valid/out_ready  result handshake (outputs held until accepted)
//   result, hi           low word/quotient, high word/remainder
//   zero, ovf, err       result==0, signed ADD/SUB overflow, illegal/div0
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  state_t           state_r;
  logic             accept_s;
  logic             start_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] sc_result_s;
  logic             sc_ovf_s;
  logic             sc_err_s;
  logic             iter_done_s;
  logic [WIDTH-1:0] iter_lo_s;
  logic [WIDTH-1:0] iter_hi_s;

`ifdef ALU_DIV_EN
  logic             div_r;       // op in flight is DIVU
  logic             div_zero_r;  // its divisor was zero
`endif

  // in_ready is a register that is only ever high in IDLE.
  assign accept_s = in_valid && in_ready && (state_r == IDLE);
  assign start_s  = accept_s && is_multicycle(control);

  alu_mc_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (start_s),
`ifdef ALU_DIV_EN
    .div_op  (control == OP_DIVU),
`endif
    .a       (a),
    .b       (b),
    .done    (iter_done_s),
    .lo_next (iter_lo_s),
    .hi_next (iter_hi_s)
  );

  // Single-cycle datapath; anything not decoded here is illegal.
  always_comb begin
    sum_s       = a + b;
    diff_s      = a - b;
    sc_result_s = {WIDTH{1'b0}};
    sc_ovf_s    = 1'b0;
    sc_err_s    = 1'b0;
    case (control)
      OP_AND:  sc_result_s = a & b;
      OP_OR:   sc_result_s = a | b;
      OP_ADD: begin
        sc_result_s = sum_s;
        sc_ovf_s    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result_s = diff_s;
        sc_ovf_s    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  sc_result_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_result_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  sc_result_s = ~(a | b);
      default: sc_err_s = 1'b1;
    endcase
  end

  // Handshake FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      result     <= {WIDTH{1'b0}};
      hi         <= {WIDTH{1'b0}};
      zero       <= 1'b0;
      ovf        <= 1'b0;
      err        <= 1'b0;
`ifdef ALU_DIV_EN
      div_r      <= 1'b0;
      div_zero_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            in_ready <= 1'b0;
            if (is_multicycle(control)) begin
              state_r    <= BUSY;
`ifdef ALU_DIV_EN
              div_r      <= (control == OP_DIVU);
              div_zero_r <= (b == {WIDTH{1'b0}});
`endif
            end else begin
              state_r   <= DONE;
              out_valid <= 1'b1;
              result    <= sc_result_s;
              hi        <= {WIDTH{1'b0}};
              zero      <= (sc_result_s == {WIDTH{1'b0}});
              ovf       <= sc_ovf_s;
              err       <= sc_err_s;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        BUSY: begin
          // Capture the last iteration's output on the same edge.
          if (iter_done_s) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            result    <= iter_lo_s;
            hi        <= iter_hi_s;
            zero      <= (iter_lo_s == {WIDTH{1'b0}});
            ovf       <= 1'b0;
`ifdef ALU_DIV_EN
            err       <= div_r && div_zero_r;
`else
            err       <= 1'b0;
`endif
          end
        end
        DONE: begin
          // Outputs hold until taken; in_ready rises the following cycle.
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
